// File: rtl/uno_pkg.sv
// Shared definitions for the uno sequencer: op codes, controller states and the
// default operand width.
package uno_pkg;

   localparam int MAC_BW = 12;

   typedef enum logic [1:0] {
      OP_MAC = 2'b00,
      OP_DIV = 2'b01,
      OP_EXP = 2'b10,
      OP_LOG = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MACS,
      ST_POLY,
      ST_DRAIN,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/uno_coeff_rf.sv
// Polynomial coefficient table: 4 ops x 16 index slots, synchronous write,
// combinational read. Slots at or above ORDER are never written by the controller.
module uno_coeff_rf #(
   parameter int MAC_BW = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [1:0]        wr_op,
   input  logic [3:0]        wr_idx,
   input  logic [MAC_BW-1:0] wr_data,
   input  logic [1:0]        rd_op,
   input  logic [3:0]        rd_idx,
   output logic [MAC_BW-1:0] rd_data
);

   logic [MAC_BW-1:0] mem [64];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the table must read back as zero after reset, so this memory is built from resettable flops rather than a RAM macro.
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else if (we) begin
         mem[{wr_op, wr_idx}] <= wr_data;
      end
   end

   assign rd_data = mem[{rd_op, rd_idx}];

endmodule

// File: rtl/uno_ctrl.sv
// Request sequencer for the uno processing element: drives registered uno controls,
// walks the Horner steps for div/exp/log and returns one captured mac_o per request.
module uno_ctrl #(
   parameter int MAC_BW  = uno_pkg::MAC_BW,
   parameter int ORDER   = 4,
   parameter int MAC_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [MAC_BW-1:0]   req_x,
   input  logic [MAC_BW-1:0]   req_y,
   input  logic [2*MAC_BW-1:0] req_z,
   input  logic                req_last,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_op,
   input  logic [3:0]          cfg_idx,
   input  logic [MAC_BW-1:0]   cfg_data,
   output logic                cfg_err,
   output logic [1:0]          uno_op,
   output logic [MAC_BW-1:0]   uno_x,
   output logic [MAC_BW-1:0]   uno_y,
   output logic [2*MAC_BW-1:0] uno_z,
   output logic [MAC_BW-1:0]   uno_coeff,
   output logic                uno_first,
   output logic                uno_last,
   output logic                uno_acc_en,
   input  logic [2*MAC_BW-1:0] mac_o,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [2*MAC_BW-1:0] res_data
);
   import uno_pkg::*;

   localparam int         DW        = 2 * MAC_BW;
   localparam int         DCW       = $clog2(MAC_LAT + 2);
   localparam logic [3:0] LAST_STEP = 4'(ORDER);

   state_e            state, state_n;
   op_e               op_q, op_n;
   logic [MAC_BW-1:0] x_q, x_n, y_q, y_n;
   logic [3:0]        step_q, step_n, poly_step, rd_idx;
   logic [DCW-1:0]    drain_q, drain_n;
   logic [1:0]        rd_op, uno_op_n;
   logic [MAC_BW-1:0] rd_data, uno_x_n, uno_y_n, uno_coeff_n;
   logic [DW-1:0]     uno_z_n, res_data_n;
   logic              uno_first_n, uno_last_n, uno_acc_en_n, res_valid_n;
   logic              accept, cfg_ok;

   assign req_ready = (state == ST_IDLE) || (state == ST_MACS);
   assign accept    = req_valid && req_ready;
   // A write is refused when its index is out of range or its op is being evaluated.
   assign cfg_ok    = cfg_we && (cfg_idx < LAST_STEP) && !((state == ST_POLY) && (cfg_op == op_q));

   // The table is read for the step about to be registered, not the one on the outputs.
   assign poly_step = (state == ST_POLY) ? step_q + 4'd1 : 4'd0;
   assign rd_op     = (state == ST_POLY) ? op_q : req_op;
   assign rd_idx    = LAST_STEP - 4'd1 - poly_step;

   uno_coeff_rf #(.MAC_BW(MAC_BW)) u_coeff_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (cfg_ok),
      .wr_op   (cfg_op),
      .wr_idx  (cfg_idx),
      .wr_data (cfg_data),
      .rd_op   (rd_op),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
      state_n      = state;
      op_n         = op_q;
      x_n          = x_q;
      y_n          = y_q;
      step_n       = step_q;
      drain_n      = drain_q;
      uno_op_n     = OP_MAC;
      uno_x_n      = '0;
      uno_y_n      = '0;
      uno_z_n      = '0;
      uno_coeff_n  = '0;
      uno_first_n  = 1'b0;
      uno_last_n   = 1'b0;
      uno_acc_en_n = 1'b1;
      res_valid_n  = res_valid;
      res_data_n   = res_data;
      unique case (state)
         ST_IDLE: if (accept) begin
            if (req_op == OP_MAC) begin
               uno_x_n      = req_x;
               uno_y_n      = req_y;
               uno_z_n      = req_z;
               uno_acc_en_n = 1'b0;
               // The last beat is still on the uno inputs during the first drain cycle.
               if (req_last) begin
                  state_n = ST_DRAIN;
                  drain_n = DCW'(MAC_LAT + 1);
               end else begin
                  state_n = ST_MACS;
               end
            end else begin
               op_n        = op_e'(req_op);
               x_n         = req_x;
               y_n         = req_y;
               step_n      = '0;
               state_n     = ST_POLY;
               uno_op_n    = req_op;
               uno_x_n     = req_x;
               uno_y_n     = req_y;
               uno_coeff_n = rd_data;
               uno_first_n = 1'b1;
            end
         end
         ST_MACS: if (accept) begin
            if (req_op == OP_MAC) begin
               uno_x_n = req_x;
               uno_y_n = req_y;
            end
            // A non-MAC op here closes the vector and its operands are dropped.
            if (req_last || (req_op != OP_MAC)) begin
               state_n = ST_DRAIN;
               drain_n = DCW'(MAC_LAT + 1);
            end
         end
         ST_POLY: begin
            if (step_q == LAST_STEP) begin
               state_n = ST_DRAIN;
               drain_n = DCW'(MAC_LAT);
            end else begin
               step_n      = poly_step;
               uno_op_n    = op_q;
               uno_x_n     = x_q;
               uno_y_n     = y_q;
               uno_last_n  = (poly_step == LAST_STEP);
               uno_coeff_n = uno_last_n ? '0 : rd_data;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DCW'(1)) begin
               res_valid_n = 1'b1;
               res_data_n  = mac_o;
               state_n     = ST_HOLD;
            end else begin
               drain_n = drain_q - DCW'(1);
            end
         end
         ST_HOLD: if (res_ready) begin
            res_valid_n = 1'b0;
            state_n     = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         op_q       <= OP_MAC;
         x_q        <= '0;
         y_q        <= '0;
         step_q     <= '0;
         drain_q    <= '0;
         uno_op     <= '0;
         uno_x      <= '0;
         uno_y      <= '0;
         uno_z      <= '0;
         uno_coeff  <= '0;
         uno_first  <= 1'b0;
         uno_last   <= 1'b0;
         uno_acc_en <= 1'b1;
         res_valid  <= 1'b0;
         res_data   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_n;
         op_q       <= op_n;
         x_q        <= x_n;
         y_q        <= y_n;
         step_q     <= step_n;
         drain_q    <= drain_n;
         uno_op     <= uno_op_n;
         uno_x      <= uno_x_n;
         uno_y      <= uno_y_n;
         uno_z      <= uno_z_n;
         uno_coeff  <= uno_coeff_n;
         uno_first  <= uno_first_n;
         uno_last   <= uno_last_n;
         uno_acc_en <= uno_acc_en_n;
         res_valid  <= res_valid_n;
         res_data   <= res_data_n;
         cfg_err    <= cfg_we && !cfg_ok;
      end
   end

endmodule

// File: tb/tb_uno_ctrl.sv
// Self-checking bench for uno_ctrl: behavioural uno accumulator, polynomial/dot-product
// reference model and a result scoreboard drained by an independent monitor.
`timescale 1ns/1ps
module tb_uno_ctrl;
   import uno_pkg::*;

   localparam int BW  = 12;
   localparam int ORD = 4;
   localparam int DW  = 2 * BW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready, req_last;
   logic [1:0]    req_op;
   logic [BW-1:0] req_x, req_y;
   logic [DW-1:0] req_z;
   logic          cfg_we, cfg_err;
   logic [1:0]    cfg_op;
   logic [3:0]    cfg_idx;
   logic [BW-1:0] cfg_data;
   logic [1:0]    uno_op;
   logic [BW-1:0] uno_x, uno_y, uno_coeff;
   logic [DW-1:0] uno_z, mac_o, res_data;
   logic          uno_first, uno_last, uno_acc_en;
   logic          res_valid, res_ready;

   uno_ctrl #(.MAC_BW(BW), .ORDER(ORD), .MAC_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_last(req_last),
      .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_err(cfg_err),
      .uno_op(uno_op), .uno_x(uno_x), .uno_y(uno_y), .uno_z(uno_z), .uno_coeff(uno_coeff),
      .uno_first(uno_first), .uno_last(uno_last), .uno_acc_en(uno_acc_en),
      .mac_o(mac_o), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   // Behavioural uno with one cycle of latency: MAC accumulates, poly ops run Horner then scale by Y.
   logic [DW-1:0] acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                acc <= '0;
      else if (uno_op == 2'b00)  acc <= (uno_acc_en ? acc : uno_z) + DW'(uno_x) * DW'(uno_y);
      else if (uno_first)        acc <= DW'(uno_coeff);
      else if (uno_last)         acc <= acc * DW'(uno_y);
      else                       acc <= acc * DW'(uno_x) + DW'(uno_coeff);
   end
   assign mac_o = acc;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [BW-1:0] tab [4][ORD];
   logic          rand_rdy_en = 1'b0;
   logic          rdy_force = 1'b1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: coefficient i multiplies x^i; the final step scales the sum by y.
   function automatic logic [DW-1:0] ref_poly(input int op, input logic [BW-1:0] x, input logic [BW-1:0] y);
      logic [DW-1:0] sum, pw;
      sum = '0;
      pw  = DW'(1);
      for (int i = 0; i < ORD; i++) begin
         sum = sum + DW'(tab[op][i]) * pw;
         pw  = pw * DW'(x);
      end
      return sum * DW'(y);
   endfunction

   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         res_ready = rand_rdy_en ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   end

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) check("res_unexpected", 64'(exp_q.size()), 64'd1);
         else                   check("res_data", res_data, exp_q.pop_front());
      end
   end

   task automatic send(input logic [1:0] op, input logic [BW-1:0] x, input logic [BW-1:0] y,
                       input logic [DW-1:0] z, input logic last);
      int n = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_z = z; req_last = last;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 100) begin
            check("req_ready_timeout", req_ready, 1'b1);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_z = '0; req_last = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] op, input logic [3:0] idx, input logic [BW-1:0] d);
      cfg_we = 1'b1; cfg_op = op; cfg_idx = idx; cfg_data = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      @(negedge clk);
      check("cfg_err", cfg_err, 64'(idx >= 4'(ORD)));
      if (idx < 4'(ORD)) tab[op][int'(idx)] = d;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("result_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic rand_mac();
      int            nb;
      logic [BW-1:0] xs[4], ys[4];
      logic [DW-1:0] z, sum;
      logic          viol;
      logic [1:0]    bad_op;
      nb     = $urandom_range(1, 4);
      z      = DW'($urandom);
      viol   = (nb > 1) && ($urandom_range(0, 4) == 0);
      bad_op = 2'($urandom_range(1, 3));
      sum    = z;
      for (int i = 0; i < nb; i++) begin
         xs[i] = BW'($urandom);
         ys[i] = BW'($urandom);
         if (!(viol && i == nb - 1)) sum = sum + DW'(xs[i]) * DW'(ys[i]);
      end
      exp_q.push_back(sum);
      for (int i = 0; i < nb; i++) begin
         if (viol && i == nb - 1) send(bad_op, xs[i], ys[i], DW'($urandom), 1'b0);
         else send(2'b00, xs[i], ys[i], (i == 0) ? z : DW'($urandom), i == nb - 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic rand_poly();
      logic [1:0]    op;
      logic [BW-1:0] x, y;
      op = 2'($urandom_range(1, 3));
      x  = BW'($urandom);
      y  = BW'($urandom);
      exp_q.push_back(ref_poly(int'(op), x, y));
      send(op, x, y, '0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] e;
      int            n;
      req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_z = '0; req_last = 1'b0;
      cfg_we = 1'b0; cfg_op = '0; cfg_idx = '0; cfg_data = '0;
      for (int o = 0; o < 4; o++) for (int i = 0; i < ORD; i++) tab[o][i] = '0;

      // Reset values while rst_n is held low.
      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_acc_en", uno_acc_en, 1'b1);
      check("rst_uno_op", uno_op, 2'b00);
      check("rst_coeff", uno_coeff, '0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_data", res_data, '0);
      check("rst_cfg_err", cfg_err, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // MAC Z=10, (2,3) then (4,5) last.
      exp_q.push_back(DW'(36));
      send(2'b00, 12'd2, 12'd3, DW'(10), 1'b0);
      @(negedge clk);
      check("mac_b0_x", uno_x, 12'd2);
      check("mac_b0_y", uno_y, 12'd3);
      check("mac_b0_z", uno_z, DW'(10));
      check("mac_b0_acc_en", uno_acc_en, 1'b0);
      send(2'b00, 12'd4, 12'd5, '0, 1'b1);
      @(negedge clk);
      check("mac_b1_x", uno_x, 12'd4);
      check("mac_b1_acc_en", uno_acc_en, 1'b1);
      wait_done();

      // Same vector with a gap between beats.
      exp_q.push_back(DW'(36));
      send(2'b00, 12'd2, 12'd3, DW'(10), 1'b0);
      @(negedge clk);
      check("gap_b0_acc_en", uno_acc_en, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("gap_bubble_x", uno_x, '0);
         check("gap_bubble_y", uno_y, '0);
         check("gap_bubble_acc_en", uno_acc_en, 1'b1);
      end
      send(2'b00, 12'd4, 12'd5, '0, 1'b1);
      wait_done();

      // exp with table {1,2,3,4}, out-of-range index, and a write to the busy op.
      for (int i = 0; i < ORD; i++) cfg_write(2'b10, 4'(i), BW'(i + 1));
      cfg_write(2'b01, 4'd4, 12'd77);
      exp_q.push_back(ref_poly(2, 12'd3, 12'd2));
      send(2'b10, 12'd3, 12'd2, '0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k <= 5) begin
            check("exp_coeff", uno_coeff, BW'(5 - k));
            check("exp_first", uno_first, 64'(k == 1));
            check("exp_last", uno_last, 64'(k == 5));
         end
         if (k >= 5) check("exp_res_valid", res_valid, 64'(k == 7));
         if (k == 2) begin
            check("exp_req_ready", req_ready, 1'b0);
            cfg_we = 1'b1; cfg_op = 2'b10; cfg_idx = 4'd0; cfg_data = 12'd99;
         end
         if (k == 3) begin
            check("busy_cfg_err", cfg_err, 1'b1);
            cfg_we = 1'b0;
         end
         if (k == 4) check("busy_cfg_err_pulse", cfg_err, 1'b0);
      end
      wait_done();
      exp_q.push_back(ref_poly(2, 12'd5, 12'd7));
      send(2'b10, 12'd5, 12'd7, '0, 1'b0);
      wait_done();

      // Result held under backpressure, then accept the cycle after the handshake.
      rdy_force = 1'b0;
      for (int i = 0; i < ORD; i++) cfg_write(2'b01, 4'(i), BW'($urandom));
      e = ref_poly(1, 12'd9, 12'd11);
      exp_q.push_back(e);
      send(2'b01, 12'd9, 12'd11, '0, 1'b0);
      n = 0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hold_res_valid_seen", res_valid, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("hold_res_data", res_data, e);
         check("hold_res_valid", res_valid, 1'b1);
         check("hold_req_ready", req_ready, 1'b0);
      end
      rdy_force = 1'b1;
      n = 0;
      while (!(res_valid && res_ready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("hs_req_ready", req_ready, 1'b0);
      @(negedge clk);
      check("post_hs_req_ready", req_ready, 1'b1);
      check("post_hs_res_valid", res_valid, 1'b0);
      wait_done();

      // Reset during POLY at s=2.
      send(2'b10, 12'd3, 12'd4, '0, 1'b0);
      repeat (3) @(negedge clk);
      check("pre_rst_coeff", uno_coeff, BW'(2));
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_coeff", uno_coeff, '0);
      check("mid_rst_first", uno_first, 1'b0);
      check("mid_rst_x", uno_x, '0);
      check("mid_rst_op", uno_op, 2'b00);
      check("mid_rst_acc_en", uno_acc_en, 1'b1);
      check("mid_rst_res_valid", res_valid, 1'b0);
      check("mid_rst_req_ready", req_ready, 1'b1);
      for (int o = 0; o < 4; o++) for (int i = 0; i < ORD; i++) tab[o][i] = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("post_rst_no_result", res_valid, 1'b0);
      end
      exp_q.push_back(ref_poly(2, 12'd3, 12'd4));
      send(2'b10, 12'd3, 12'd4, '0, 1'b0);
      repeat (4) begin
         @(negedge clk);
         check("post_rst_table", uno_coeff, '0);
      end
      wait_done();

      // Randomized traffic with random result backpressure.
      rand_rdy_en = 1'b1;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) == 0)
            cfg_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 5)), BW'($urandom));
         if ($urandom_range(0, 1) == 0) rand_mac();
         else rand_poly();
         wait_done();
      end
      rand_rdy_en = 1'b0;
      repeat (3) @(negedge clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
